// File: rtl/present_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : present_slot_scheduler
//  Description : Owns the present (gift) slots. Allocates a free slot on a
//                bubble-pop spawn request, ages each present in frames,
//                blinks it before expiry and frees it on collect or expiry.
//  Revision    : 1.0  initial release
// ============================================================================
module present_slot_scheduler #(
    parameter int NUM_SLOTS    = 3,
    parameter int LIFE_FRAMES  = 300,
    parameter int BLINK_FRAMES = 90,
    parameter int BLINK_PERIOD = 8,
    parameter int KIND_W       = 2,
    parameter int CNT_W        = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startOfFrame,
    input  logic                          gameActive,
    input  logic                          spawnReq,
    input  logic [10:0]                   spawnX,
    input  logic [10:0]                   spawnY,
    input  logic [KIND_W-1:0]             spawnKind,
    input  logic [NUM_SLOTS-1:0]          collect,
    output logic [NUM_SLOTS-1:0]          slotActive,
    output logic [NUM_SLOTS-1:0]          slotVisible,
    output logic [NUM_SLOTS*11-1:0]       slotX,
    output logic [NUM_SLOTS*11-1:0]       slotY,
    output logic [NUM_SLOTS*KIND_W-1:0]   slotKind,
    output logic                          collectPulse,
    output logic [KIND_W-1:0]             collectedKind,
    output logic [1:0]                    collectedSlot,
    output logic [7:0]                    dropCount
);

    localparam int               c_BC_W       = $clog2(BLINK_PERIOD + 1);
    localparam logic [c_BC_W-1:0] c_BLINK_LAST = c_BC_W'(BLINK_PERIOD - 1);
    localparam logic [CNT_W-1:0]  c_LIFE       = CNT_W'(LIFE_FRAMES);
    localparam logic [CNT_W-1:0]  c_BLINK_AT   = CNT_W'(BLINK_FRAMES);
    localparam logic [CNT_W-1:0]  c_ONE        = CNT_W'(1);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLINK  = 2'd2
    } slot_state_t;

    logic [NUM_SLOTS-1:0] w_busy;
    logic                 w_spawn_hit;
    logic [1:0]           w_spawn_idx;
    logic                 w_coll_hit;
    logic [1:0]           w_coll_idx;
    logic                 w_do_spawn;
    logic                 w_do_collect;

    // Lowest-index free slot for spawning and lowest-index collectable slot.
    // Both look at slot state from the start of the cycle, so a slot freed by
    // a collect this cycle cannot also be picked for a spawn this cycle.
    always_comb begin
        w_spawn_hit = 1'b0;
        w_spawn_idx = 2'd0;
        w_coll_hit  = 1'b0;
        w_coll_idx  = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_spawn_hit = 1'b1;
                w_spawn_idx = 2'(i);
            end
            if (collect[i] && w_busy[i]) begin
                w_coll_hit = 1'b1;
                w_coll_idx = 2'(i);
            end
        end
    end

    assign w_do_spawn   = gameActive && spawnReq && w_spawn_hit;
    assign w_do_collect = gameActive && w_coll_hit;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        slot_state_t         r_state;
        slot_state_t         w_state_nxt;
        logic [CNT_W-1:0]    r_life;
        logic [CNT_W-1:0]    w_life_nxt;
        logic [c_BC_W-1:0]   r_blink;
        logic [c_BC_W-1:0]   w_blink_nxt;
        logic                r_vis;
        logic                w_vis_nxt;
        logic [10:0]         r_x;
        logic [10:0]         r_y;
        logic [KIND_W-1:0]   r_kind;
        logic                w_take_spawn;
        logic                w_take_coll;

        assign w_take_spawn = w_do_spawn   && (w_spawn_idx == 2'(gi));
        assign w_take_coll  = w_do_collect && (w_coll_idx  == 2'(gi));

        // Slot lifecycle: spawn, frame aging, blink toggling, collect/expiry.
        always_comb begin
            w_state_nxt = r_state;
            w_life_nxt  = r_life;
            w_blink_nxt = r_blink;
            w_vis_nxt   = r_vis;
            if (!gameActive) begin
                w_state_nxt = S_FREE;
                w_life_nxt  = '0;
                w_blink_nxt = '0;
                w_vis_nxt   = 1'b0;
            end else begin
                case (r_state)
                    S_FREE: begin
                        if (w_take_spawn) begin
                            w_state_nxt = S_ACTIVE;
                            w_life_nxt  = c_LIFE;
                            w_blink_nxt = '0;
                            w_vis_nxt   = 1'b1;
                        end
                    end
                    S_ACTIVE, S_BLINK: begin
                        if (w_take_coll) begin
                            // Collect wins over an expiry in the same cycle.
                            w_state_nxt = S_FREE;
                            w_vis_nxt   = 1'b0;
                        end else if (startOfFrame) begin
                            w_life_nxt = r_life - c_ONE;
                            if (r_life == c_ONE) begin
                                w_state_nxt = S_FREE;
                                w_vis_nxt   = 1'b0;
                            end else if (r_state == S_ACTIVE) begin
                                if ((r_life - c_ONE) == c_BLINK_AT) begin
                                    w_state_nxt = S_BLINK;
                                    w_blink_nxt = '0;
                                    w_vis_nxt   = 1'b1;
                                end
                            end else if (r_blink == c_BLINK_LAST) begin
                                w_blink_nxt = '0;
                                w_vis_nxt   = ~r_vis;
                            end else begin
                                w_blink_nxt = r_blink + c_BC_W'(1);
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = S_FREE;
                        w_vis_nxt   = 1'b0;
                    end
                endcase
            end
        end

        // Slot state and held present attributes.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= S_FREE;
                r_life  <= '0;
                r_blink <= '0;
                r_vis   <= 1'b0;
                r_x     <= '0;
                r_y     <= '0;
                r_kind  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_life  <= w_life_nxt;
                r_blink <= w_blink_nxt;
                r_vis   <= w_vis_nxt;
                if (!gameActive) begin
                    r_x    <= '0;
                    r_y    <= '0;
                    r_kind <= '0;
                end else if (w_take_spawn) begin
                    r_x    <= spawnX;
                    r_y    <= spawnY;
                    r_kind <= spawnKind;
                end
            end
        end

        assign w_busy[gi]                     = (r_state != S_FREE);
        assign slotActive[gi]                 = (r_state != S_FREE);
        assign slotVisible[gi]                = (r_state != S_FREE) && r_vis;
        assign slotX[11*gi +: 11]             = r_x;
        assign slotY[11*gi +: 11]             = r_y;
        assign slotKind[KIND_W*gi +: KIND_W]  = r_kind;
    end

    // Collect report and saturating count of refused spawns.
    always_ff @(posedge clk) begin
        if (reset) begin
            collectPulse  <= 1'b0;
            collectedKind <= '0;
            collectedSlot <= 2'd0;
            dropCount     <= 8'd0;
        end else begin
            collectPulse  <= w_do_collect;
            collectedSlot <= w_do_collect ? w_coll_idx : 2'd0;
            collectedKind <= w_do_collect ? slotKind[int'(w_coll_idx)*KIND_W +: KIND_W] : '0;
            if (gameActive && spawnReq && !w_spawn_hit && (dropCount != 8'hFF)) begin
                dropCount <= dropCount + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
